// File: rtl/amax10_qsys_nios2_gen2_oci_dct_packer_if.sv
// amax10_qsys_nios2_gen2_oci_dct_packer_if: code-in / frame-out bundle of the OCI DCT packer
// Ports: code_valid/code/code_ready (code stream), flush, test_end_req,
//        dct_buffer/dct_count/frame_valid/frame_ready (frame handshake),
//        test_ending/test_has_ended (end-of-test signalling).
// Modport master is the packer; modport slave is the code source / trace sink.
interface amax10_qsys_nios2_gen2_oci_dct_packer_if #(
  parameter int CODE_W = 2,
  parameter int BUF_W  = 30,
  parameter int CNT_W  = 4
);
  logic              code_valid;
  logic [CODE_W-1:0] code;
  logic              code_ready;
  logic              flush;
  logic              test_end_req;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              frame_valid;
  logic              frame_ready;
  logic              test_ending;
  logic              test_has_ended;
  modport master (
    input  code_valid, code, flush, test_end_req, frame_ready,
    output code_ready, dct_buffer, dct_count, frame_valid, test_ending, test_has_ended
  );
  modport slave (
    output code_valid, code, flush, test_end_req, frame_ready,
    input  code_ready, dct_buffer, dct_count, frame_valid, test_ending, test_has_ended
  );
endinterface

// File: rtl/amax10_qsys_nios2_gen2_oci_dct_packer.sv
// amax10_qsys_nios2_gen2_oci_dct_packer: packs 2-bit trace codes into 30-bit DCT frames
// Ports: clk (rising edge), reset_n (async active-low), bus (master modport):
//        code stream in, frame handshake out, end-of-test strobe and sticky flag.
module amax10_qsys_nios2_gen2_oci_dct_packer #(
  parameter int CODE_W = 2,
  parameter int SLOTS  = 15,
  parameter int BUF_W  = 30,
  parameter int CNT_W  = 4
) (
  input logic clk,
  input logic reset_n,
  amax10_qsys_nios2_gen2_oci_dct_packer_if.master bus
);
  typedef enum logic [1:0] {FILL, EMIT, ENDING, ENDED} state_t;
  state_t           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d, buf_a;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_a;
  logic             end_pending_q, end_pending_d;
  logic             accept, end_req, go_emit;
  // code_ready depends only on registered state, gated low while in reset
  assign bus.code_ready     = reset_n && state_q == FILL && !end_pending_q;
  assign bus.frame_valid    = state_q == EMIT;
  assign bus.test_ending    = state_q == ENDING;
  assign bus.test_has_ended = state_q == ENDED;
  assign bus.dct_buffer     = buf_q;
  assign bus.dct_count      = cnt_q;
  assign accept  = bus.code_valid && bus.code_ready;
  assign end_req = end_pending_q || bus.test_end_req;
  // post-accept view so a code arriving with flush/end is included in the frame
  assign cnt_a   = cnt_q + CNT_W'(accept);
  assign buf_a   = accept ? {buf_q[BUF_W-CODE_W-1:0], bus.code} : buf_q;
  assign go_emit = cnt_a == CNT_W'(SLOTS) || (cnt_a != '0 && (bus.flush || end_req));
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    end_pending_d = end_pending_q || (bus.test_end_req && state_q != ENDED);
    case (state_q)
      FILL: begin
        buf_d   = buf_a;
        cnt_d   = cnt_a;
        state_d = go_emit ? EMIT : end_req ? ENDING : FILL;
      end
      EMIT: if (bus.frame_ready) begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = end_req ? ENDING : FILL;
      end
      default: state_d = ENDED;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FILL;
      buf_q         <= '0;
      cnt_q         <= '0;
      end_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      end_pending_q <= end_pending_d;
    end
  end
endmodule

// File: tb/tb_amax10_qsys_nios2_gen2_oci_dct_packer.sv
// tb_amax10_qsys_nios2_gen2_oci_dct_packer: directed table-driven bench for the DCT packer
module tb_amax10_qsys_nios2_gen2_oci_dct_packer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  typedef struct {
    logic        v;
    logic [1:0]  c;
    logic        f;
    logic        t;
    logic        r;
    logic        e_cr;
    logic        e_fv;
    logic [3:0]  e_cnt;
    logic [29:0] e_buf;
    logic        cb;
  } vec_t;
  vec_t tbl[$];
  amax10_qsys_nios2_gen2_oci_dct_packer_if #(.CODE_W(2), .BUF_W(30), .CNT_W(4)) bus ();
  amax10_qsys_nios2_gen2_oci_dct_packer #(.CODE_W(2), .SLOTS(15), .BUF_W(30), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic vec_t mk(logic v, logic [1:0] c, logic f, logic t, logic r,
                              logic e_cr, logic e_fv, logic [3:0] e_cnt, logic [29:0] e_buf, logic cb);
    vec_t x;
    x.v = v; x.c = c; x.f = f; x.t = t; x.r = r;
    x.e_cr = e_cr; x.e_fv = e_fv; x.e_cnt = e_cnt; x.e_buf = e_buf; x.cb = cb;
    return x;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic expect_out(input string tag, input logic cr, input logic fv, input logic [3:0] cnt,
                            input logic [29:0] b, input logic cb, input logic te, input logic the);
    chk({tag, ".code_ready"}, 32'(bus.code_ready), 32'(cr));
    chk({tag, ".frame_valid"}, 32'(bus.frame_valid), 32'(fv));
    chk({tag, ".dct_count"}, 32'(bus.dct_count), 32'(cnt));
    if (cb) chk({tag, ".dct_buffer"}, 32'(bus.dct_buffer), 32'(b));
    chk({tag, ".test_ending"}, 32'(bus.test_ending), 32'(te));
    chk({tag, ".test_has_ended"}, 32'(bus.test_has_ended), 32'(the));
  endtask
  task automatic drive(input logic v, input logic [1:0] c, input logic f, input logic t, input logic r);
    @(negedge clk);
    bus.code_valid = v; bus.code = c; bus.flush = f; bus.test_end_req = t; bus.frame_ready = r;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.code_valid = 1'b0; bus.code = '0; bus.flush = 1'b0; bus.test_end_req = 1'b0; bus.frame_ready = 1'b0;
    #1;
    expect_out("in_reset", 1'b0, 1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask
  initial begin
    bus.code_valid = 1'b0; bus.code = '0; bus.flush = 1'b0; bus.test_end_req = 1'b0; bus.frame_ready = 1'b0;
    for (int i = 0; i < 14; i++) tbl.push_back(mk(1, 2'(i % 4), 0, 0, 1, 1, 0, 4'(i + 1), 30'd0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 1, 0, 1, 15, 30'h06C6C6C6, 1));
    tbl.push_back(mk(1, 3, 0, 0, 1, 1, 0, 0, 30'h0, 1));
    tbl.push_back(mk(1, 3, 0, 0, 0, 1, 0, 1, 30'h3, 1));
    tbl.push_back(mk(1, 2, 0, 0, 0, 1, 0, 2, 30'hE, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 3, 30'h39, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 3, 30'h39, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 3, 30'h39, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 30'h0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 30'h0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 30'h0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 30'h0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 2, 30'h1, 1));
    tbl.push_back(mk(1, 3, 0, 0, 0, 1, 0, 3, 30'h7, 1));
    tbl.push_back(mk(1, 3, 0, 0, 0, 1, 0, 4, 30'h1F, 1));
    tbl.push_back(mk(1, 2, 1, 0, 0, 0, 1, 5, 30'h7E, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 30'h0, 1));
    do_reset();
    expect_out("after_reset", 1'b1, 1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].c, tbl[k].f, tbl[k].t, tbl[k].r);
      expect_out($sformatf("vec%0d", k), tbl[k].e_cr, tbl[k].e_fv, tbl[k].e_cnt, tbl[k].e_buf, tbl[k].cb, 1'b0, 1'b0);
    end
    drive(1, 1, 0, 0, 0);
    drive(1, 2, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    expect_out("bp_emit", 1'b0, 1'b1, 4'd2, 30'h6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 3, 0, 0, 0);
      expect_out($sformatf("bp_hold%0d", i), 1'b0, 1'b1, 4'd2, 30'h6, 1'b1, 1'b0, 1'b0);
    end
    drive(1, 3, 0, 0, 1);
    expect_out("bp_release", 1'b1, 1'b0, 4'd0, 30'h0, 1'b1, 1'b0, 1'b0);
    drive(1, 3, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    expect_out("bp_next", 1'b0, 1'b1, 4'd2, 30'hC, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 2, 0, 0, 0);
    drive(1, 3, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    expect_out("end_fill", 1'b1, 1'b0, 4'd6, 30'h1B1, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 1, 0);
    expect_out("end_emit", 1'b0, 1'b1, 4'd6, 30'h1B1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      expect_out($sformatf("end_wait%0d", i), 1'b0, 1'b1, 4'd6, 30'h1B1, 1'b1, 1'b0, 1'b0);
    end
    drive(0, 0, 0, 0, 1);
    expect_out("end_strobe", 1'b0, 1'b0, 4'd0, 30'h0, 1'b1, 1'b1, 1'b0);
    drive(1, 1, 1, 0, 1);
    expect_out("ended", 1'b0, 1'b0, 4'd0, 30'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 1, 1, 1);
      expect_out($sformatf("ended_hold%0d", i), 1'b0, 1'b0, 4'd0, 30'h0, 1'b1, 1'b0, 1'b1);
    end
    do_reset();
    expect_out("rst_clears_end", 1'b1, 1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1, 1, 0, 0, 0);
    expect_out("rst_fill7", 1'b1, 1'b0, 4'd7, 30'h1555, 1'b1, 1'b0, 1'b0);
    #3 reset_n = 1'b0;
    #1 expect_out("rst_async_fill", 1'b0, 1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
    bus.code_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 expect_out("rst_release_fill", 1'b1, 1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1);
      expect_out($sformatf("rst_nostale_fill%0d", i), 1'b1, 1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) drive(1, 2, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    expect_out("rst_emit", 1'b0, 1'b1, 4'd3, 30'h2A, 1'b1, 1'b0, 1'b0);
    #3 reset_n = 1'b0;
    #1 expect_out("rst_async_emit", 1'b0, 1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      expect_out($sformatf("rst_nostale_emit%0d", i), 1'b1, 1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/amax10_qsys_nios2_gen2_oci_dct_packer.md
Name: amax10_qsys_nios2_gen2_oci_dct_packer

Overview:
- Producer side of the OCI data-compression-trace (DCT) frame interface.
- Packs a stream of 2-bit trace codes into 30-bit frames (dct_buffer) with a slot count (dct_count).
- Hands each frame to the OCI trace sink over a valid/ready handshake.
- Sequences end-of-test signalling: test_ending, then test_has_ended, delivered to the same consumer.

Parameters:
- CODE_W, 2: width of one trace code.
- SLOTS, 15: codes per full frame.
- BUF_W, 30: frame width; must equal CODE_W*SLOTS.
- CNT_W, 4: slot-count width; must satisfy 2^CNT_W > SLOTS.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- code_valid  input  1  trace code offered.
- code  input  CODE_W  trace code.
- code_ready  output  1  packer accepts code this cycle.
- flush  input  1  emit the partial frame.
- test_end_req  input  1  request end-of-test sequence.
- dct_buffer  output  BUF_W  packed frame.
- dct_count  output  CNT_W  valid slots in dct_buffer.
- frame_valid  output  1  frame presented.
- frame_ready  input  1  consumer accepts frame.
- test_ending  output  1  one-cycle end-of-test strobe.
- test_has_ended  output  1  sticky end-of-test flag.

Behaviour:
- Reset (async assert, sync release):
  - state=FILL, dct_buffer=0, dct_count=0, frame_valid=0.
  - test_ending=0, test_has_ended=0, end_pending=0.
  - code_ready is forced 0 while reset_n=0.
  - Reset mid-frame discards buffer contents; no frame is emitted.
- States: FILL, EMIT, ENDING, ENDED.
- code_ready = (state==FILL) && !end_pending. It is combinational from registered state only; it has no path from code_valid.
- FILL, accept (code_valid && code_ready):
  - dct_buffer <= {dct_buffer[BUF_W-CODE_W-1:0], code}, so the newest code sits in bits [1:0].
  - dct_count <= dct_count+1.
  - Unfilled upper slots are always 0.
- FILL -> EMIT, next cycle, on any of:
  - an accept that brings the count to SLOTS;
  - flush=1 with post-accept count > 0;
  - end_pending (or test_end_req this cycle) with post-accept count > 0.
- Accept and flush in the same cycle: the code is included, then the frame is emitted.
- flush with count 0 is ignored; no empty frames are ever emitted.
- EMIT:
  - frame_valid=1; dct_buffer and dct_count are held stable until frame_ready.
  - code_ready=0; flush is ignored.
  - On frame_ready: buffer and count clear to 0, frame_valid drops the next cycle, and state goes to ENDING if end_pending, else FILL.
  - No combinational frame_ready->code_ready path; at most one frame every 2 cycles.
- test_end_req (sampled level, any state before ENDED):
  - Sets end_pending (sticky until reset); code_ready drops the next cycle.
  - In FILL with count 0, go to ENDING.
  - Asserting test_end_req during EMIT is honoured after the handshake.
- ENDING: test_ending=1 for exactly one cycle, then go to ENDED.
- ENDED: test_has_ended=1 held until reset; code_ready=0; all inputs are ignored.
- dct_count never exceeds SLOTS. Frame order is strictly acceptance order; no code is dropped or duplicated.

Test Plan:
- Full frame: after reset, offer 15 codes 0,1,2,3,0,1,... back-to-back with frame_ready=1.
  - Required: frame_valid rises 1 cycle after the 15th accept, with dct_count=15 and dct_buffer=30'h06C6C6C6 (oldest code in [29:28]).
  - Next cycle: count=0 and code_ready=1.
- Partial flush: accept codes 3,2,1, then flush=1 alone.
  - Required: frame dct_count=3, dct_buffer=30'h00000039.
  - Flush with count 0 produces no frame_valid.
- Backpressure: frame_ready=0 for 10 cycles while code_valid=1.
  - Required: code_ready=0 and dct_buffer/dct_count stable throughout.
  - After frame_ready, the next frame contains subsequent codes only, with none lost.
- Simultaneous: flush=1 in the same cycle as the accept of code 2 on count=4.
  - Required: emitted dct_count=5 with code 2 in bits [1:0].
- End sequence: test_end_req with count=6 and frame_ready delayed 3 cycles.
  - Required: the 6-slot frame is emitted first, then test_ending=1 for one cycle, then test_has_ended=1 held.
  - code_valid is ignored afterwards.
- Reset mid-frame: reset_n=0 at count=7 during FILL, and again during EMIT.
  - Required: all outputs 0 immediately (async).
  - After release: count=0, no stale frame, code_ready=1.
